// File: rtl/dir_txn_sequencer.sv
// Directory read-modify-write sequencer: one coherence transaction at a time, lookup -> update -> response.
// Optional wait-state watchdog enabled by defining DIR_SEQ_TIMEOUT_EN.
`ifndef NUM_L1_CACHES
`define NUM_L1_CACHES 4
`endif
`ifndef WADDR
`define WADDR 16
`endif
`ifndef DIR_STATE_INVALID
`define DIR_STATE_INVALID 3'd0
`endif
`ifndef DIR_STATE_SHARED
`define DIR_STATE_SHARED 3'd1
`endif
`ifndef DIR_STATE_EXCLUSIVE
`define DIR_STATE_EXCLUSIVE 3'd2
`endif

module dir_txn_sequencer #(
    parameter int unsigned NUM_L1 = `NUM_L1_CACHES,
    parameter int unsigned AW     = `WADDR
`ifdef DIR_SEQ_TIMEOUT_EN
    , parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [AW-1:0]     req_addr,
    input  logic [NUM_L1-1:0] req_src,
    input  logic [1:0]        req_op,
    output logic              lookup_req,
    output logic [AW-1:0]     lookup_addr,
    input  logic              lookup_valid,
    input  logic [2:0]        lookup_state,
    input  logic [NUM_L1-1:0] lookup_presence,
    input  logic [NUM_L1-1:0] lookup_tip_state,
    output logic              update_req,
    output logic [AW-1:0]     update_addr,
    output logic [2:0]        update_state,
    output logic [NUM_L1-1:0] update_presence,
    output logic [NUM_L1-1:0] update_tip_state,
    input  logic              update_done,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [NUM_L1-1:0] resp_probe_mask,
    output logic [2:0]        resp_state,
    output logic              resp_err
);
    localparam logic [1:0] OP_ACQ_B = 2'd0;
    localparam logic [1:0] OP_ACQ_T = 2'd1;
    localparam logic [1:0] OP_REL   = 2'd2;

    typedef enum logic [2:0] {IDLE, LK_REQ, LK_WAIT, UPD_REQ, UPD_WAIT, RESP} state_t;

    state_t             state;
    logic [AW-1:0]      addr_q;
    logic [NUM_L1-1:0]  src_q;
    logic [1:0]         op_q;
    logic [NUM_L1-1:0]  probe_c;
    logic [NUM_L1-1:0]  npres_c;
    logic [NUM_L1-1:0]  ntip_c;
    logic [2:0]         nstate_c;

    // The stored line state is fully implied by presence/tip, so the directory's copy is not needed.
    logic unused_lookup_state;
    assign unused_lookup_state = ^lookup_state;

`ifdef DIR_SEQ_TIMEOUT_EN
    localparam int unsigned CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CW-1:0] cnt;
    logic          expired_c;
    assign expired_c = (cnt == CW'(TIMEOUT_CYCLES - 1));
`endif

    // Next directory entry and probe set from the lookup result.
    always_comb begin
        probe_c = '0;
        npres_c = lookup_presence;
        ntip_c  = lookup_tip_state;
        case (op_q)
            OP_ACQ_B: begin
                probe_c = lookup_tip_state & ~src_q;
                npres_c = lookup_presence | src_q;
                ntip_c  = lookup_tip_state & src_q;
            end
            OP_ACQ_T: begin
                probe_c = lookup_presence & ~src_q;
                npres_c = src_q;
                ntip_c  = src_q;
            end
            OP_REL: begin
                npres_c = lookup_presence & ~src_q;
                ntip_c  = lookup_tip_state & ~src_q;
            end
            default: ntip_c = lookup_tip_state & ~src_q;
        endcase
        if (npres_c == '0)
            nstate_c = 3'(`DIR_STATE_INVALID);
        else if (ntip_c != '0)
            nstate_c = 3'(`DIR_STATE_EXCLUSIVE);
        else
            nstate_c = 3'(`DIR_STATE_SHARED);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= IDLE;
            addr_q           <= '0;
            src_q            <= '0;
            op_q             <= '0;
            req_ready        <= 1'b1;
            lookup_req       <= 1'b0;
            lookup_addr      <= '0;
            update_req       <= 1'b0;
            update_addr      <= '0;
            update_state     <= '0;
            update_presence  <= '0;
            update_tip_state <= '0;
            resp_valid       <= 1'b0;
            resp_probe_mask  <= '0;
            resp_state       <= '0;
            resp_err         <= 1'b0;
`ifdef DIR_SEQ_TIMEOUT_EN
            cnt              <= '0;
`endif
        end else begin
            lookup_req <= 1'b0;
            update_req <= 1'b0;
`ifdef DIR_SEQ_TIMEOUT_EN
            cnt        <= '0;
`endif
            case (state)
                IDLE: if (req_valid) begin
                    addr_q    <= req_addr;
                    src_q     <= req_src;
                    op_q      <= req_op;
                    req_ready <= 1'b0;
                    if ($onehot(req_src)) begin
                        lookup_req  <= 1'b1;
                        lookup_addr <= req_addr;
                        state       <= LK_REQ;
                    end else begin
                        resp_valid      <= 1'b1;
                        resp_err        <= 1'b1;
                        resp_probe_mask <= '0;
                        resp_state      <= 3'(`DIR_STATE_INVALID);
                        state           <= RESP;
                    end
                end
                LK_REQ: state <= LK_WAIT;
                LK_WAIT: begin
                    if (lookup_valid) begin
                        update_req       <= 1'b1;
                        update_addr      <= addr_q;
                        update_state     <= nstate_c;
                        update_presence  <= npres_c;
                        update_tip_state <= ntip_c;
                        resp_probe_mask  <= probe_c;
                        resp_state       <= nstate_c;
                        state            <= UPD_REQ;
                    end
`ifdef DIR_SEQ_TIMEOUT_EN
                    else if (expired_c) begin
                        resp_valid      <= 1'b1;
                        resp_err        <= 1'b1;
                        resp_probe_mask <= '0;
                        resp_state      <= 3'(`DIR_STATE_INVALID);
                        state           <= RESP;
                    end else
                        cnt <= cnt + CW'(1);
`endif
                end
                UPD_REQ: state <= UPD_WAIT;
                UPD_WAIT: begin
                    if (update_done) begin
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        state      <= RESP;
                    end
`ifdef DIR_SEQ_TIMEOUT_EN
                    else if (expired_c) begin
                        resp_valid      <= 1'b1;
                        resp_err        <= 1'b1;
                        resp_probe_mask <= '0;
                        resp_state      <= 3'(`DIR_STATE_INVALID);
                        state           <= RESP;
                    end else
                        cnt <= cnt + CW'(1);
`endif
                end
                RESP: if (resp_ready) begin
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dir_txn_sequencer.sv
// Scoreboard bench for dir_txn_sequencer with a 2-cycle lookup/update directory model.
// Define DIR_SEQ_TIMEOUT_EN to also exercise the lookup watchdog.
`ifndef DIR_STATE_INVALID
`define DIR_STATE_INVALID 3'd0
`endif
`ifndef DIR_STATE_SHARED
`define DIR_STATE_SHARED 3'd1
`endif
`ifndef DIR_STATE_EXCLUSIVE
`define DIR_STATE_EXCLUSIVE 3'd2
`endif

module tb_dir_txn_sequencer;
    localparam logic [2:0] INV = `DIR_STATE_INVALID;
    localparam logic [2:0] SH  = `DIR_STATE_SHARED;
    localparam logic [2:0] EX  = `DIR_STATE_EXCLUSIVE;
    localparam logic [1:0] ACQ_B = 2'd0, ACQ_T = 2'd1, REL = 2'd2, REL_B = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready;
    logic [15:0] req_addr;
    logic [3:0]  req_src;
    logic [1:0]  req_op;
    logic        lookup_req;
    logic [15:0] lookup_addr;
    logic        lookup_valid;
    logic [2:0]  lookup_state;
    logic [3:0]  lookup_presence, lookup_tip_state;
    logic        update_req;
    logic [15:0] update_addr;
    logic [2:0]  update_state;
    logic [3:0]  update_presence, update_tip_state;
    logic        update_done;
    logic        resp_valid, resp_ready;
    logic [3:0]  resp_probe_mask;
    logic [2:0]  resp_state;
    logic        resp_err;

    dir_txn_sequencer #(
        .NUM_L1(4), .AW(16)
`ifdef DIR_SEQ_TIMEOUT_EN
        , .TIMEOUT_CYCLES(8)
`endif
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_src(req_src), .req_op(req_op),
        .lookup_req(lookup_req), .lookup_addr(lookup_addr), .lookup_valid(lookup_valid),
        .lookup_state(lookup_state), .lookup_presence(lookup_presence),
        .lookup_tip_state(lookup_tip_state),
        .update_req(update_req), .update_addr(update_addr), .update_state(update_state),
        .update_presence(update_presence), .update_tip_state(update_tip_state),
        .update_done(update_done),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_probe_mask(resp_probe_mask),
        .resp_state(resp_state), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    typedef struct { logic [15:0] addr; logic [2:0] st; logic [3:0] pres; logic [3:0] tip; } upd_t;
    typedef struct { logic [3:0] probe; logic [2:0] st; logic err; int lat; } rsp_t;
    upd_t upd_q[$];
    rsp_t rsp_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = -1;
    int lk_n = 0;
    int up_n = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Edge counter and acceptance timestamp (pre-edge values of DUT outputs).
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst_n && req_valid && req_ready) acc_cyc = cyc;
    end

    // Directory model: result two cycles after the request cycle, stored per line.
    logic [3:0] mem_p [0:255];
    logic [3:0] mem_t [0:255];
    logic [2:0] mem_s [0:255];
    int         lk_cnt = 0, up_cnt = 0;
    logic [7:0] lk_a;
    logic       suppress = 1'b0;

    always @(negedge clk) begin
        if (lookup_valid) lookup_valid = 1'b0;
        if (update_done) update_done = 1'b0;
        if (lk_cnt != 0) begin
            lk_cnt--;
            if (lk_cnt == 0) begin
                lookup_valid     = 1'b1;
                lookup_presence  = mem_p[lk_a];
                lookup_tip_state = mem_t[lk_a];
                lookup_state     = mem_s[lk_a];
            end
        end
        if (up_cnt != 0) begin
            up_cnt--;
            if (up_cnt == 0) begin
                update_done = 1'b1;
                mem_p[update_addr[7:0]] = update_presence;
                mem_t[update_addr[7:0]] = update_tip_state;
                mem_s[update_addr[7:0]] = update_state;
            end
        end
        if (lookup_req && !suppress) begin
            lk_cnt = 2;
            lk_a   = lookup_addr[7:0];
        end
        if (update_req) up_cnt = 2;
    end

    // Monitor: pops the scoreboard on each update pulse and each new response.
    logic       rsp_active = 1'b0;
    logic [3:0] snap_probe;
    logic [2:0] snap_st;
    logic       snap_err;
    always @(negedge clk) begin
        upd_t u;
        rsp_t r;
        if (lookup_req) lk_n++;
        if (update_req) up_n++;
        if (lookup_req || update_req) chk("lk_upd_overlap", 32'(lookup_req & update_req), 0);
        if (update_req) begin
            if (upd_q.size() == 0) chk("upd_unexpected", 1, 0);
            else begin
                u = upd_q.pop_front();
                chk("upd_addr", 32'(update_addr), 32'(u.addr));
                chk("upd_state", 32'(update_state), 32'(u.st));
                chk("upd_presence", 32'(update_presence), 32'(u.pres));
                chk("upd_tip", 32'(update_tip_state), 32'(u.tip));
            end
        end
        if (resp_valid) begin
            if (!rsp_active) begin
                rsp_active = 1'b1;
                snap_probe = resp_probe_mask;
                snap_st    = resp_state;
                snap_err   = resp_err;
                if (rsp_q.size() == 0) chk("resp_unexpected", 1, 0);
                else begin
                    r = rsp_q.pop_front();
                    chk("resp_probe", 32'(resp_probe_mask), 32'(r.probe));
                    chk("resp_state", 32'(resp_state), 32'(r.st));
                    chk("resp_err", 32'(resp_err), 32'(r.err));
                    if (r.lat >= 0) chk("resp_latency", 32'(cyc - acc_cyc), 32'(r.lat));
                end
            end else begin
                chk("resp_hold", {resp_probe_mask, resp_state, resp_err}, {snap_probe, snap_st, snap_err});
            end
            if (resp_ready) rsp_active = 1'b0;
        end
    end

    task automatic exp_txn(input logic [15:0] a, input logic [3:0] pres, input logic [3:0] tip,
                           input logic [3:0] probe, input logic [2:0] st);
        upd_q.push_back('{addr: a, st: st, pres: pres, tip: tip});
        rsp_q.push_back('{probe: probe, st: st, err: 1'b0, lat: 6});
    endtask

    task automatic drive(input logic [15:0] a, input logic [3:0] s, input logic [1:0] op);
        req_addr  = a;
        req_src   = s;
        req_op    = op;
        req_valid = 1'b1;
    endtask

    task automatic wait_accept(input string nm);
        int n = 0;
        do begin
            @(posedge clk); #2;
            n++;
        end while (acc_cyc != cyc && n < 60);
        chk(nm, 32'(acc_cyc == cyc), 1);
        req_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while (n < 100 && !(rsp_q.size() == 0 && upd_q.size() == 0 && req_ready && !resp_valid)) begin
            @(posedge clk); #2;
            n++;
        end
        chk(nm, 32'(rsp_q.size() == 0 && upd_q.size() == 0 && req_ready && !resp_valid), 1);
    endtask

    task automatic run(input string nm, input logic [15:0] a, input logic [3:0] s, input logic [1:0] op,
                       input logic [3:0] pres, input logic [3:0] tip, input logic [3:0] probe,
                       input logic [2:0] st);
        exp_txn(a, pres, tip, probe, st);
        drive(a, s, op);
        wait_accept({"accept_", nm});
        drain({"drain_", nm});
    endtask

    initial begin
        int sl, su;
        for (int i = 0; i < 256; i++) begin
            mem_p[i] = '0; mem_t[i] = '0; mem_s[i] = INV;
        end
        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_src = '0; req_op = '0;
        resp_ready = 1'b1; lookup_valid = 1'b0; update_done = 1'b0;
        lookup_state = '0; lookup_presence = '0; lookup_tip_state = '0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_req_ready", 32'(req_ready), 1);
        chk("rst_outputs", {lookup_req, update_req, resp_valid, resp_err, update_state, resp_probe_mask}, 0);
        rst_n = 1'b1;
        @(posedge clk); #2;

        // Sharing sequence on one line.
        run("acqt_0001", 16'h10, 4'b0001, ACQ_T, 4'b0001, 4'b0001, 4'b0000, EX);
        run("acqb_0010", 16'h10, 4'b0010, ACQ_B, 4'b0011, 4'b0000, 4'b0001, SH);
        run("acqt_0100", 16'h10, 4'b0100, ACQ_T, 4'b0100, 4'b0100, 4'b0011, EX);
        run("rel_0100",  16'h10, 4'b0100, REL,   4'b0000, 4'b0000, 4'b0000, INV);
        run("acqt_0010", 16'h30, 4'b0010, ACQ_T, 4'b0010, 4'b0010, 4'b0000, EX);
        run("relb_0010", 16'h30, 4'b0010, REL_B, 4'b0010, 4'b0000, 4'b0000, SH);

        // Response back-pressure with a second request waiting.
        resp_ready = 1'b0;
        exp_txn(16'h24, 4'b1000, 4'b0000, 4'b0000, SH);
        drive(16'h24, 4'b1000, ACQ_B);
        wait_accept("accept_stall_a");
        exp_txn(16'h24, 4'b1000, 4'b0000, 4'b0000, SH);
        drive(16'h24, 4'b1000, REL_B);
        for (int n = 0; n < 20 && !resp_valid; n++) begin
            @(posedge clk); #2;
        end
        chk("stall_resp_seen", 32'(resp_valid), 1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #2;
            chk("stall_req_ready", 32'(req_ready), 0);
            chk("stall_resp_valid", 32'(resp_valid), 1);
            chk("stall_no_accept", 32'(acc_cyc == cyc), 0);
        end
        resp_ready = 1'b1;
        wait_accept("accept_stall_b");
        drain("drain_stall");

        // Non-one-hot requesters are rejected without touching the directory.
        sl = lk_n; su = up_n;
        rsp_q.push_back('{probe: 4'b0000, st: INV, err: 1'b1, lat: -1});
        drive(16'h40, 4'b0110, ACQ_T);
        wait_accept("accept_err_0110");
        drain("drain_err_0110");
        rsp_q.push_back('{probe: 4'b0000, st: INV, err: 1'b1, lat: -1});
        drive(16'h40, 4'b0000, REL);
        wait_accept("accept_err_0000");
        drain("drain_err_0000");
        chk("err_no_lookup", 32'(lk_n), 32'(sl));
        chk("err_no_update", 32'(up_n), 32'(su));

        // Reset while waiting for update_done; the late done must be ignored.
        upd_q.push_back('{addr: 16'h50, st: EX, pres: 4'b0001, tip: 4'b0001});
        drive(16'h50, 4'b0001, ACQ_T);
        wait_accept("accept_rst");
        repeat (4) @(posedge clk);
        #2;
        chk("pre_rst_busy", 32'(req_ready), 0);
        rst_n = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        chk("midrst_req_ready", 32'(req_ready), 1);
        chk("midrst_outputs", {lookup_req, update_req, resp_valid, resp_err, resp_state, resp_probe_mask}, 0);
        chk("midrst_upd_regs", {update_addr, update_state, update_presence, update_tip_state}, 0);
        chk("midrst_lookup_addr", 32'(lookup_addr), 0);
        repeat (2) @(posedge clk);
        #2;
        chk("stray_done_idle", {req_ready, resp_valid, update_req, lookup_req}, 4'b1000);
        run("post_rst", 16'h50, 4'b0010, ACQ_B, 4'b0010, 4'b0000, 4'b0000, SH);

`ifdef DIR_SEQ_TIMEOUT_EN
        // Lookup never answered: watchdog fires after 8 cycles in LK_WAIT.
        suppress = 1'b1;
        su = up_n;
        rsp_q.push_back('{probe: 4'b0000, st: INV, err: 1'b1, lat: 9});
        drive(16'h60, 4'b0001, ACQ_T);
        wait_accept("accept_timeout");
        drain("drain_timeout");
        chk("timeout_no_update", 32'(up_n), 32'(su));
        suppress = 1'b0;
`endif

        chk("queues_empty", 32'(rsp_q.size() + upd_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench watchdog expired");
    end
endmodule

// File: doc/dir_txn_sequencer.md
Name: dir_txn_sequencer

Overview:
- Front-end transaction sequencer placed directly upstream of the directory storage block; it is the only master of the directory's lookup and update ports.
- Accepts one coherence transaction at a time: L1 acquire or release, carrying address and requester.
- Performs a directory read-modify-write: issues a lookup, computes the next state, presence and tip vectors, then issues an update.
- Returns a response with the probe mask the home agent must service.

Parameters:
NUM_L1, `NUM_L1_CACHES, number of L1 caches (presence/tip vector width)
AW, `WADDR, line address width
TIMEOUT_CYCLES, 255, wait-state watchdog limit (used only with DIR_SEQ_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
req_valid  in  1  transaction valid
req_ready  out  1  sequencer can accept
req_addr  in  AW  line address
req_src  in  NUM_L1  requester, one-hot
req_op  in  2  0=ACQ_B, 1=ACQ_T, 2=RELEASE, 3=RELEASE_TO_B
lookup_req  out  1  one-cycle lookup pulse
lookup_addr  out  AW  lookup address
lookup_valid  in  1  lookup result valid
lookup_state  in  3  DIR_STATE_* of line
lookup_presence  in  NUM_L1  current presence
lookup_tip_state  in  NUM_L1  current tip vector
update_req  out  1  one-cycle update pulse
update_addr  out  AW  update address
update_state  out  3  new DIR_STATE_*
update_presence  out  NUM_L1  new presence
update_tip_state  out  NUM_L1  new tip vector
update_done  in  1  update complete
resp_valid  out  1  response valid
resp_ready  in  1  response accepted
resp_probe_mask  out  NUM_L1  caches to probe
resp_state  out  3  state written
resp_err  out  1  transaction failed; no update performed

Behaviour:
- Reset: synchronous, active-low. Sampled at a clk edge with rst_n=0 it forces IDLE and zeroes every output and register, except req_ready=1 once out of reset. It applies mid-transaction too; late lookup_valid/update_done pulses are ignored in IDLE.
- FSM states: IDLE, LK_REQ, LK_WAIT, UPD_REQ, UPD_WAIT, RESP.
- IDLE: req_ready=1 only here. On req_valid, capture addr/src/op.
  - src not exactly one-hot: go to RESP with resp_err=1 and no directory access.
  - Otherwise go to LK_REQ.
- LK_REQ: lookup_req=1 for exactly one cycle; lookup_addr = captured addr, held until IDLE. Next state LK_WAIT.
- LK_WAIT: on lookup_valid, register the next values and go to UPD_REQ. With P=lookup_presence, T=lookup_tip_state, s=req_src:
  - ACQ_B: probe=T&~s; nP=P|s; nT=T&s.
  - ACQ_T: probe=P&~s; nP=s; nT=s.
  - RELEASE: probe=0; nP=P&~s; nT=T&~s.
  - RELEASE_TO_B: probe=0; nP=P; nT=T&~s.
  - nState: INVALID if nP==0; else EXCLUSIVE if nT!=0; else SHARED (`DIR_STATE_* macros).
- UPD_REQ: update_req=1 for exactly one cycle. The update_* outputs are driven from registers and held stable through UPD_WAIT, because the directory samples them one cycle after the request.
- UPD_WAIT: on update_done go to RESP with resp_err=0.
- RESP: resp_valid=1; all resp_* fields stable until resp_valid&&resp_ready. Then go to IDLE and clear resp_valid.
- Latency: acceptance at edge E0 gives lookup_req in cycle E0..E1 and resp_valid visible after E6 (6 cycles), assuming the directory's 2-cycle lookup and 2-cycle update.
- lookup_req and update_req are never high in the same cycle; at most one transaction is in flight.

Optional Feature:
DIR_SEQ_TIMEOUT_EN:
- Defined: an 8-bit-or-wider counter runs in LK_WAIT/UPD_WAIT and clears on every state change. Reaching TIMEOUT_CYCLES forces RESP with resp_err=1, resp_probe_mask=0, resp_state=`DIR_STATE_INVALID; no further update_req is issued.
- Undefined: no counter; the wait states wait indefinitely. resp_err is then driven only by the one-hot check.

Test Plan (NUM_L1=4, directory model with 2-cycle lookup/update):
- Empty directory; ACQ_T src=0001 addr=0x10 -> update state=EXCLUSIVE, presence=0001, tip=0001; resp probe=0000; resp_valid exactly 6 cycles after acceptance.
- Then ACQ_B src=0010 addr=0x10 -> probe=0001; update presence=0011, tip=0000, state=SHARED.
- Then ACQ_T src=0100 -> probe=0011; presence=tip=0100, EXCLUSIVE. Then RELEASE src=0100 -> presence=0000, state=INVALID, probe=0000.
- resp_ready held low 5 cycles -> resp_* stable, req_ready=0, second req_valid not accepted. Separately, req_src=0110 -> resp_err=1 with no lookup_req or update_req pulse.
- rst_n low for one edge while in UPD_WAIT -> next cycle IDLE, all outputs 0, req_ready=1; stray update_done ignored.
- DIR_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=8, lookup_valid never returned -> resp_err=1 after 8 cycles in LK_WAIT, no update_req.
